// File: rtl/approx_rc_adder_pipe.sv
// Two-stage approximate ripple-carry adder with exact reference,
// per-sample absolute error and saturating error/sample accumulators.
module approx_rc_adder_pipe #(
    parameter int WIDTH       = 16,
    parameter int APPROX_BITS = 8,
    parameter int ACC_W       = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             mode,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_err,
    output logic [ACC_W-1:0] err_acc,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int SW = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;
    localparam int CW = CNT_W + 1;

    logic             s1_v;
    logic [WIDTH-1:0] s1_lo;
    logic             s1_c;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_mode;
    logic [WIDTH:0]   s1_exact;
    logic             s2_v;

    logic s1_adv;
    logic s2_adv;
    logic xfer;

    assign s2_adv    = ~s2_v | out_ready;
    assign s1_adv    = ~s1_v | s2_adv;
    assign in_ready  = s1_adv & ~rst;
    assign out_valid = s2_v;
    assign xfer      = s2_v & out_ready;

    // Low segment: approximate cells unless mode forces exact ones.
    // Upper operand bits are kept masked so stage 2 adds only them.
    logic [WIDTH-1:0] lo_c_sum;
    logic [WIDTH-1:0] hi_a;
    logic [WIDTH-1:0] hi_b;
    logic             lo_c;

    always_comb begin
        lo_c     = 1'b0;
        lo_c_sum = '0;
        hi_a     = '0;
        hi_b     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < APPROX_BITS) begin
                if (mode) begin
                    lo_c_sum[i] = in1[i] ^ in2[i] ^ lo_c;
                    lo_c = (in1[i] & in2[i]) |
                           (lo_c & (in1[i] ^ in2[i]));
                end else begin
                    lo_c_sum[i] = in1[i] & ~lo_c;
                    lo_c = 1'b1;
                end
            end else begin
                hi_a[i] = in1[i];
                hi_b[i] = in2[i];
            end
        end
    end

    logic [WIDTH:0] sum_c;
    logic [WIDTH:0] err_c;

    always_comb begin
        sum_c = ({1'b0, s1_a} + {1'b0, s1_b} +
                 ((WIDTH + 1)'(s1_c) << APPROX_BITS)) |
                {1'b0, s1_lo};
        if (s1_mode)
            err_c = '0;
        else if (sum_c > s1_exact)
            err_c = sum_c - s1_exact;
        else
            err_c = s1_exact - sum_c;
    end

    logic [SW-1:0]    acc_base;
    logic [SW-1:0]    acc_next;
    logic [ACC_W-1:0] acc_sat;
    logic [CW-1:0]    cnt_base;
    logic [CW-1:0]    cnt_next;
    logic [CNT_W-1:0] cnt_sat;

    // A clear coinciding with a transfer restarts from that sample.
    always_comb begin
        acc_base = acc_clear ? '0 : SW'(err_acc);
        acc_next = acc_base + (xfer ? SW'(out_err) : '0);
        if (acc_next > SW'({ACC_W{1'b1}}))
            acc_sat = '1;
        else
            acc_sat = acc_next[ACC_W-1:0];
        cnt_base = acc_clear ? '0 : CW'(sample_cnt);
        cnt_next = cnt_base + CW'(xfer);
        if (cnt_next[CNT_W])
            cnt_sat = '1;
        else
            cnt_sat = cnt_next[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v       <= 1'b0;
            s1_lo      <= '0;
            s1_c       <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_mode    <= 1'b0;
            s1_exact   <= '0;
            s2_v       <= 1'b0;
            out_sum    <= '0;
            out_err    <= '0;
            err_acc    <= '0;
            sample_cnt <= '0;
        end else begin
            if (s1_adv) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_lo    <= lo_c_sum;
                    s1_c     <= lo_c;
                    s1_a     <= hi_a;
                    s1_b     <= hi_b;
                    s1_mode  <= mode;
                    s1_exact <= {1'b0, in1} + {1'b0, in2};
                end
            end
            if (s2_adv) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    out_sum <= sum_c;
                    out_err <= err_c;
                end
            end
            err_acc    <= acc_sat;
            sample_cnt <= cnt_sat;
        end
    end

endmodule
